// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - parametrised synchronous FIFO with registered read data, flags and ack/err pulses
module fifo_param #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 3,
    parameter int AF_LEVEL = (1 << ADDR_W) - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [WIDTH-1:0]  d_in,
    output logic [WIDTH-1:0]  d_out,
    output logic [ADDR_W:0]   data_count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              wr_ack,
    output logic              wr_err,
    output logic              rd_ack,
    output logic              rd_err
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        INIT, NO_OP, WRITE, READ, WR_RD, WR_ERR, RD_ERR
    } state_t;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_acc;
    logic              rd_acc;
    logic              wr_rej;
    logic              rd_rej;
    logic              wr_ack_q;
    logic              rd_ack_q;
    state_t            state;

    assign full         = (32'(data_count) == DEPTH);
    assign empty        = (data_count == '0);
    assign almost_full  = (32'(data_count) >= AF_LEVEL);
    assign almost_empty = (32'(data_count) <= AE_LEVEL);

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;
    assign wr_rej = wr_en & full;
    assign rd_rej = rd_en & empty;

    // Storage has no reset; contents after reset are never observable before a write.
    always_ff @(posedge clk) begin
        if (reset_n && wr_acc) begin
            mem[wr_ptr] <= d_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            data_count <= '0;
            d_out      <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
                d_out  <= mem[rd_ptr];
            end
            if (wr_acc && !rd_acc) begin
                data_count <= data_count + (ADDR_W+1)'(1);
            end else if (rd_acc && !wr_acc) begin
                data_count <= data_count - (ADDR_W+1)'(1);
            end
        end
    end

    // Error states take priority so a rejection is never hidden by a concurrent accept.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= INIT;
            wr_ack_q <= 1'b0;
            rd_ack_q <= 1'b0;
        end else begin
            wr_ack_q <= wr_acc;
            rd_ack_q <= rd_acc;
            if (wr_rej) begin
                state <= WR_ERR;
            end else if (rd_rej) begin
                state <= RD_ERR;
            end else if (wr_acc && rd_acc) begin
                state <= WR_RD;
            end else if (wr_acc) begin
                state <= WRITE;
            end else if (rd_acc) begin
                state <= READ;
            end else begin
                state <= NO_OP;
            end
        end
    end

    // A rejected read can pair with an accepted write (and vice versa), so acks keep their own flops.
    assign wr_ack = wr_ack_q;
    assign rd_ack = rd_ack_q;
    assign wr_err = (state == WR_ERR);
    assign rd_err = (state == RD_ERR);
endmodule

// File: tb/tb_fifo_param.sv
// tb/tb_fifo_param.sv - directed self-checking bench for fifo_param
module tb_fifo_param;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] d_in;
    logic [31:0] d_out;
    logic [3:0]  data_count;
    logic        full, empty, almost_full, almost_empty;
    logic        wr_ack, wr_err, rd_ack, rd_err;

    int checks = 0;
    int errors = 0;

    fifo_param #(.WIDTH(32), .ADDR_W(3)) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .rd_en(rd_en), .d_in(d_in),
        .d_out(d_out), .data_count(data_count), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .wr_ack(wr_ack), .wr_err(wr_err), .rd_ack(rd_ack), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic w, input logic r, input logic [31:0] d);
        wr_en = w;
        rd_en = r;
        d_in  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_pulses(input string tag, input logic wa, input logic we,
                                input logic ra, input logic re);
        check({tag, " wr_ack"}, 32'(wr_ack), 32'(wa));
        check({tag, " wr_err"}, 32'(wr_err), 32'(we));
        check({tag, " rd_ack"}, 32'(rd_ack), 32'(ra));
        check({tag, " rd_err"}, 32'(rd_err), 32'(re));
    endtask

    initial begin
        reset_n = 1'b0;
        wr_en = 1'b1;
        rd_en = 1'b1;
        d_in = 32'h55;
        cyc(1'b1, 1'b1, 32'h55);
        cyc(1'b1, 1'b1, 32'h55);
        check("rst count", 32'(data_count), 32'd0);
        check("rst empty", 32'(empty), 32'd1);
        check("rst ae", 32'(almost_empty), 32'd1);
        check("rst full", 32'(full), 32'd0);
        check("rst af", 32'(almost_full), 32'd0);
        check("rst d_out", d_out, 32'd0);
        check_pulses("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;

        // Fill 0xA0..0xA7
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, 32'hA0 + 32'(i));
            check_pulses("fill", 1'b1, 1'b0, 1'b0, 1'b0);
            check("fill count", 32'(data_count), 32'(i + 1));
            check("fill af", 32'(almost_full), 32'(i + 1 >= 7));
            check("fill full", 32'(full), 32'(i + 1 == 8));
            check("fill ae", 32'(almost_empty), 32'(i + 1 <= 1));
            check("fill empty", 32'(empty), 32'd0);
        end
        cyc(1'b1, 1'b0, 32'hFF);
        check_pulses("overflow", 1'b0, 1'b1, 1'b0, 1'b0);
        check("overflow count", 32'(data_count), 32'd8);

        // Drain
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 32'h0);
            check_pulses("drain", 1'b0, 1'b0, 1'b1, 1'b0);
            check("drain d_out", d_out, 32'hA0 + 32'(i));
            check("drain count", 32'(data_count), 32'(7 - i));
            check("drain ae", 32'(almost_empty), 32'(7 - i <= 1));
        end
        check("drain empty", 32'(empty), 32'd1);
        cyc(1'b0, 1'b1, 32'h0);
        check_pulses("underflow", 1'b0, 1'b0, 1'b0, 1'b1);
        check("underflow d_out", d_out, 32'hA7);
        check("underflow count", 32'(data_count), 32'd0);

        // Wrap-around: move pointers to 5, then 6 more words cross 7 -> 0
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 32'hC0 + 32'(i));
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 32'h0);
            check("wrap5 d_out", d_out, 32'hC0 + 32'(i));
        end
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 32'hB0 + 32'(i));
        check("wrap count", 32'(data_count), 32'd6);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b1, 32'h0);
            check("wrap d_out", d_out, 32'hB0 + 32'(i));
        end
        check("wrap empty", 32'(empty), 32'd1);

        // Simultaneous on empty: write accepted, read rejected
        cyc(1'b1, 1'b1, 32'hD0);
        check_pulses("both empty", 1'b1, 1'b0, 1'b0, 1'b1);
        check("both empty count", 32'(data_count), 32'd1);
        check("both empty d_out", d_out, 32'hB5);
        cyc(1'b1, 1'b0, 32'hD1);
        cyc(1'b1, 1'b0, 32'hD2);
        check("mid count", 32'(data_count), 32'd3);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, 32'hE0 + 32'(i));
            check_pulses("both mid", 1'b1, 1'b0, 1'b1, 1'b0);
            check("both mid count", 32'(data_count), 32'd3);
        end
        check("both mid d_out", d_out, 32'hE0);

        // Contents now E1,E2,E3; top up to full with F0..F4
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 32'hF0 + 32'(i));
        check("topup full", 32'(full), 32'd1);
        cyc(1'b1, 1'b1, 32'h99);
        check_pulses("both full", 1'b0, 1'b1, 1'b1, 1'b0);
        check("both full count", 32'(data_count), 32'd7);
        check("both full d_out", d_out, 32'hE1);

        // Reset mid-operation at count 5
        cyc(1'b0, 1'b1, 32'h0);
        cyc(1'b0, 1'b1, 32'h0);
        check("pre-rst count", 32'(data_count), 32'd5);
        check("pre-rst d_out", d_out, 32'hE3);
        reset_n = 1'b0;
        cyc(1'b1, 1'b0, 32'h77);
        reset_n = 1'b1;
        check("midrst count", 32'(data_count), 32'd0);
        check("midrst empty", 32'(empty), 32'd1);
        check("midrst d_out", d_out, 32'd0);
        check_pulses("midrst", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 32'h0);
        check_pulses("post-rst read", 1'b0, 1'b0, 1'b0, 1'b1);
        check("post-rst count", 32'(data_count), 32'd0);
        cyc(1'b0, 1'b0, 32'h0);
        check_pulses("idle", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
